// File: rtl/regmap_pkg.sv
// Shared types and constants for the register-map front-end controller.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package regmap_pkg;

    // Default geometry of the register map this controller fronts
    localparam int DEF_NUM_REGS = 48;
    localparam int DEF_ADDR_W   = 6;
    localparam int DEF_DATA_W   = 32;

    // Shadowed host-visible addresses (never stored in the map)
    localparam int ADDR_CTRL   = 0;
    localparam int ADDR_STATUS = 1;
    localparam int ADDR_PERF   = 2;

    // CTRL register bit positions
    localparam int CTRL_START = 0;
    localparam int CTRL_CLEAR = 1;
    localparam int CTRL_ABORT = 2;

    // STATUS register bit positions
    localparam int STAT_RUN  = 0;
    localparam int STAT_DONE = 1;

    // Engine run-control state
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Write-port requesters; the value doubles as the grant bit index
    typedef enum logic {
        HOST   = 1'b0,
        ENGINE = 1'b1
    } requester_t;

    // STATUS word as seen by the host: {.., DONE, RUN}
    function automatic logic [DEF_DATA_W-1:0] status_word(input state_t s);
        logic [DEF_DATA_W-1:0] w;
        w            = '0;
        w[STAT_RUN]  = (s == RUN);
        w[STAT_DONE] = (s == DONE);
        return w;
    endfunction

endpackage

// File: rtl/regmap_ctrl_rr_arb2.sv
// Two-way round-robin arbiter for the single register-map write port.
// Latency: grant is combinational from req; rr_last updates at the grant edge.
// Backpressure: a loser simply sees no grant and must hold its request.
module rr_arb2
    import regmap_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    output logic [1:0] grant
);

    requester_t rr_last_q;

    // Single requester wins outright; on contention the side that did not win last time goes
    always_comb begin
        grant = req;
        if (&req) begin
            grant = (rr_last_q == HOST) ? 2'b10 : 2'b01;
        end
    end

    // Remember the most recent winner; reset leaves ENGINE so the host wins the first contention
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_last_q <= ENGINE;
        end else if (|grant) begin
            rr_last_q <= grant[ENGINE] ? ENGINE : HOST;
        end
    end

endmodule

// File: rtl/regmap_ctrl.sv
// Register-map front end: shares the map write port between host and engine, owns the run-control FSM.
// Latency: host response 1 cycle after accept; engine reads combinational; map writes land at the grant edge.
// Backpressure: host stalls only when its map write loses to the engine; engine writes stall outside RUN or on loss.
// Optional build macro REGMAP_CTRL_PERF_EN: read-only run-cycle counter shadowed at address 2.
module regmap_ctrl
    import regmap_pkg::*;
#(
    parameter int NUM_REGS    = DEF_NUM_REGS,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int CTRL_ADDR   = ADDR_CTRL,
    parameter int STATUS_ADDR = ADDR_STATUS
) (
    input  logic              clk,
    input  logic              rst_n,
    // host bus
    input  logic              host_req_valid,
    output logic              host_req_ready,
    input  logic              host_req_we,
    input  logic [ADDR_W-1:0] host_req_addr,
    input  logic [DATA_W-1:0] host_req_wdata,
    output logic              host_rsp_valid,
    output logic [DATA_W-1:0] host_rsp_rdata,
    output logic              host_rsp_err,
    // engine control
    output logic              eng_start,
    output logic              eng_abort,
    input  logic              eng_done,
    // engine writeback
    input  logic              eng_wr_valid,
    output logic              eng_wr_ready,
    input  logic [ADDR_W-1:0] eng_wr_addr,
    input  logic [DATA_W-1:0] eng_wr_data,
    // engine read
    input  logic [ADDR_W-1:0] eng_rd_addr,
    output logic [DATA_W-1:0] eng_rd_data,
    // register map
    output logic              rm_reg_write,
    output logic [ADDR_W-1:0] rm_write_reg,
    output logic [DATA_W-1:0] rm_write_data,
    output logic [ADDR_W-1:0] rm_read_reg1,
    input  logic [DATA_W-1:0] rm_read_data1,
    output logic [ADDR_W-1:0] rm_read_reg2,
    input  logic [DATA_W-1:0] rm_read_data2
);

    // One registered host response beat
    typedef struct packed {
        logic              vld;
        logic              err;
        logic [DATA_W-1:0] rdata;
    } rsp_t;

    // Extra bit so a map size equal to 2**ADDR_W still compares correctly
    localparam logic [ADDR_W:0] NREGS_EXT = (ADDR_W + 1)'(NUM_REGS);

    state_t            state_q;
    state_t            state_d;
    logic              start_d;
    logic              abort_d;
    logic              start_q;
    logic              abort_q;

    logic              addr_ok;
    logic              is_ctrl;
    logic              is_status;
    logic              is_perf;
    logic              host_wreq;
    logic              eng_wreq;
    logic [1:0]        wr_req;
    logic [1:0]        wr_grant;
    logic              host_accept;
    logic              ctrl_wr;
    logic [DATA_W-1:0] stat_word;
    logic [DATA_W-1:0] rdata_d;
    rsp_t              rsp_q;

    // ---------------------------------------------------------------
    // Host address decode
    // ---------------------------------------------------------------
    assign addr_ok   = ({1'b0, host_req_addr} < NREGS_EXT);
    assign is_ctrl   = (host_req_addr == ADDR_W'(CTRL_ADDR));
    assign is_status = (host_req_addr == ADDR_W'(STATUS_ADDR));
`ifdef REGMAP_CTRL_PERF_EN
    assign is_perf   = (host_req_addr == ADDR_W'(ADDR_PERF));
`else
    assign is_perf   = 1'b0;
`endif

    // Only genuine map writes compete for the write port; shadowed and errored accesses never stall
    assign host_wreq = host_req_valid & host_req_we & addr_ok & ~is_ctrl & ~is_status & ~is_perf;
    assign eng_wreq  = eng_wr_valid & (state_q == RUN);
    assign wr_req    = {eng_wreq, host_wreq};

    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (wr_req),
        .grant (wr_grant)
    );

    // ---------------------------------------------------------------
    // Register-map write port and pass-through read ports
    // ---------------------------------------------------------------
    // Gated by rst_n so nothing can reach the map while the controller is held in reset
    assign rm_reg_write  = rst_n & (|wr_grant);
    assign rm_write_reg  = wr_grant[ENGINE] ? eng_wr_addr : host_req_addr;
    assign rm_write_data = wr_grant[ENGINE] ? eng_wr_data : host_req_wdata;

    assign rm_read_reg1  = host_req_addr;
    assign rm_read_reg2  = eng_rd_addr;
    assign eng_rd_data   = rm_read_data2;

    // ---------------------------------------------------------------
    // Handshakes
    // ---------------------------------------------------------------
    assign host_req_ready = ~(host_wreq & wr_grant[ENGINE]);
    assign eng_wr_ready   = wr_grant[ENGINE];
    assign host_accept    = host_req_valid & host_req_ready;
    assign ctrl_wr        = host_accept & host_req_we & addr_ok & is_ctrl;

    assign stat_word = DATA_W'(status_word(state_q));

`ifdef REGMAP_CTRL_PERF_EN
    logic [DATA_W-1:0] perf_cnt_q;

    // Run-cycle counter: restarts on START, counts RUN cycles, sticks at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_cnt_q <= '0;
        end else if (start_d) begin
            perf_cnt_q <= '0;
        end else if ((state_q == RUN) && (perf_cnt_q != '1)) begin
            perf_cnt_q <= perf_cnt_q + 1'b1;
        end
    end
`endif

    // Read data for the response; writes, errors and CTRL reads answer zero
    always_comb begin
        rdata_d = '0;
        if (host_req_valid && !host_req_we && addr_ok) begin
            if (is_status) begin
                rdata_d = stat_word;
            end else if (is_ctrl) begin
                rdata_d = '0;
`ifdef REGMAP_CTRL_PERF_EN
            end else if (is_perf) begin
                rdata_d = perf_cnt_q;
`endif
            end else begin
                rdata_d = rm_read_data1;
            end
        end
    end

    // Response register: one beat per accepted host request, data sampled in the accept cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_q <= '0;
        end else begin
            rsp_q.vld   <= host_accept;
            rsp_q.err   <= host_accept & ~addr_ok;
            rsp_q.rdata <= host_accept ? rdata_d : '0;
        end
    end

    assign host_rsp_valid = rsp_q.vld;
    assign host_rsp_err   = rsp_q.err;
    assign host_rsp_rdata = rsp_q.rdata;

    // ---------------------------------------------------------------
    // Run-control FSM
    // ---------------------------------------------------------------
    // Next state from CTRL writes and engine completion; bits not meaningful in a state are dropped
    always_comb begin
        state_d = state_q;
        start_d = 1'b0;
        abort_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (ctrl_wr && host_req_wdata[CTRL_START]) begin
                    state_d = RUN;
                    start_d = 1'b1;
                end
            end
            RUN: begin
                // Abort beats a completion arriving in the same cycle
                if (ctrl_wr && host_req_wdata[CTRL_ABORT]) begin
                    state_d = IDLE;
                    abort_d = 1'b1;
                end else if (eng_done) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                // A restart takes priority over a clear written alongside it
                if (ctrl_wr && host_req_wdata[CTRL_START]) begin
                    state_d = RUN;
                    start_d = 1'b1;
                end else if (ctrl_wr && host_req_wdata[CTRL_CLEAR]) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register plus registered single-cycle start/abort pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            start_q <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            start_q <= start_d;
            abort_q <= abort_d;
        end
    end

    assign eng_start = start_q;
    assign eng_abort = abort_q;

endmodule

// File: tb/tb_regmap_ctrl.sv
// Self-checking bench for regmap_ctrl with an external register-map model.
// Latency: expects responses one cycle after accept and start/abort pulses in that same response cycle.
// Backpressure: exercises host/engine write-port contention and engine stall outside RUN.
module tb_regmap_ctrl;

    localparam int S_IDLE = 0;
    localparam int S_RUN  = 1;
    localparam int S_DONE = 2;

    logic        clk;
    logic        rst_n;
    logic        host_req_valid;
    logic        host_req_ready;
    logic        host_req_we;
    logic [5:0]  host_req_addr;
    logic [31:0] host_req_wdata;
    logic        host_rsp_valid;
    logic [31:0] host_rsp_rdata;
    logic        host_rsp_err;
    logic        eng_start;
    logic        eng_abort;
    logic        eng_done;
    logic        eng_wr_valid;
    logic        eng_wr_ready;
    logic [5:0]  eng_wr_addr;
    logic [31:0] eng_wr_data;
    logic [5:0]  eng_rd_addr;
    logic [31:0] eng_rd_data;
    logic        rm_reg_write;
    logic [5:0]  rm_write_reg;
    logic [31:0] rm_write_data;
    logic [5:0]  rm_read_reg1;
    logic [31:0] rm_read_data1;
    logic [5:0]  rm_read_reg2;
    logic [31:0] rm_read_data2;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: expected map contents and run state
    logic [31:0] ref_mem [64];
    int          st;

    // Register-map environment: async reads, sync write
    logic        clr_map;
    logic [31:0] map_mem [64];

    always @(posedge clk) begin
        if (clr_map) begin
            for (int i = 0; i < 64; i++) map_mem[i] <= '0;
        end else if (rm_reg_write) begin
            map_mem[rm_write_reg] <= rm_write_data;
        end
    end

    assign rm_read_data1 = map_mem[rm_read_reg1];
    assign rm_read_data2 = map_mem[rm_read_reg2];

    regmap_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .host_req_valid (host_req_valid),
        .host_req_ready (host_req_ready),
        .host_req_we    (host_req_we),
        .host_req_addr  (host_req_addr),
        .host_req_wdata (host_req_wdata),
        .host_rsp_valid (host_rsp_valid),
        .host_rsp_rdata (host_rsp_rdata),
        .host_rsp_err   (host_rsp_err),
        .eng_start      (eng_start),
        .eng_abort      (eng_abort),
        .eng_done       (eng_done),
        .eng_wr_valid   (eng_wr_valid),
        .eng_wr_ready   (eng_wr_ready),
        .eng_wr_addr    (eng_wr_addr),
        .eng_wr_data    (eng_wr_data),
        .eng_rd_addr    (eng_rd_addr),
        .eng_rd_data    (eng_rd_data),
        .rm_reg_write   (rm_reg_write),
        .rm_write_reg   (rm_write_reg),
        .rm_write_data  (rm_write_data),
        .rm_read_reg1   (rm_read_reg1),
        .rm_read_data1  (rm_read_data1),
        .rm_read_reg2   (rm_read_reg2),
        .rm_read_data2  (rm_read_data2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_status();
        logic [31:0] w;
        w    = '0;
        w[0] = (st == S_RUN);
        w[1] = (st == S_DONE);
        return w;
    endfunction

    // Spec rules for a CTRL write, with an engine completion possibly in the same cycle
    task automatic model_ctrl(input logic [2:0] b, input logic dn, output logic s, output logic ab);
        s  = 1'b0;
        ab = 1'b0;
        if (st == S_IDLE) begin
            if (b[0]) begin st = S_RUN; s = 1'b1; end
        end else if (st == S_RUN) begin
            if (b[2]) begin st = S_IDLE; ab = 1'b1; end
            else if (dn) st = S_DONE;
        end else begin
            if (b[0]) begin st = S_RUN; s = 1'b1; end
            else if (b[1]) st = S_IDLE;
        end
    endtask

    // One isolated host transaction; optional engine completion in the accept cycle
    task automatic host_txn(input logic we, input logic [5:0] a, input logic [31:0] d, input logic dn);
        logic        e_wr;
        logic        e_err;
        logic [31:0] e_rd;
        logic        e_st;
        logic        e_ab;
        @(posedge clk); #1;
        host_req_valid = 1'b1;
        host_req_we    = we;
        host_req_addr  = a;
        host_req_wdata = d;
        eng_done       = dn;
        @(negedge clk);
        e_wr = we && (a < 6'd48) && (a != 6'd0) && (a != 6'd1);
        chk("host_ready", 32'(host_req_ready), 32'd1);
        chk("host_map_we", 32'(rm_reg_write), 32'(e_wr));
        chk("start_idle", 32'(eng_start), 32'd0);
        chk("abort_idle", 32'(eng_abort), 32'd0);
        e_err = (a >= 6'd48);
        e_rd  = '0;
        e_st  = 1'b0;
        e_ab  = 1'b0;
        if (!e_err && !we) begin
            if (a == 6'd0)      e_rd = '0;
            else if (a == 6'd1) e_rd = exp_status();
            else                e_rd = ref_mem[a];
        end
        if (!e_err && we && a == 6'd0) begin
            model_ctrl(d[2:0], dn, e_st, e_ab);
        end else begin
            if (e_wr) ref_mem[a] = d;
            if (dn && st == S_RUN) st = S_DONE;
        end
        @(posedge clk); #1;
        host_req_valid = 1'b0;
        eng_done       = 1'b0;
        @(negedge clk);
        chk("rsp_valid", 32'(host_rsp_valid), 32'd1);
        chk("rsp_rdata", host_rsp_rdata, e_rd);
        chk("rsp_err", 32'(host_rsp_err), 32'(e_err));
        chk("eng_start", 32'(eng_start), 32'(e_st));
        chk("eng_abort", 32'(eng_abort), 32'(e_ab));
    endtask

    // Isolated engine writeback attempt: accepted only while running
    task automatic eng_write(input logic [5:0] a, input logic [31:0] d);
        logic exp;
        @(posedge clk); #1;
        eng_wr_valid = 1'b1;
        eng_wr_addr  = a;
        eng_wr_data  = d;
        @(negedge clk);
        exp = (st == S_RUN);
        chk("eng_wr_ready", 32'(eng_wr_ready), 32'(exp));
        chk("eng_map_we", 32'(rm_reg_write), 32'(exp));
        @(posedge clk); #1;
        eng_wr_valid = 1'b0;
        if (exp) ref_mem[a] = d;
    endtask

    task automatic eng_done_pulse();
        @(posedge clk); #1;
        eng_done = 1'b1;
        @(posedge clk); #1;
        eng_done = 1'b0;
        if (st == S_RUN) st = S_DONE;
    endtask

    task automatic eng_read(input logic [5:0] a);
        @(posedge clk); #1;
        eng_rd_addr = a;
        @(negedge clk);
        chk("eng_rd_data", eng_rd_data, ref_mem[a]);
        chk("rm_read_reg2", 32'(rm_read_reg2), 32'(a));
    endtask

    initial begin
        logic [31:0] hd [3];
        logic [31:0] ed [3];
        int          hi;
        int          ei;
        logic        gh;
        logic [5:0]  ra;
        logic [31:0] rd;
        int          sel;

        for (int i = 0; i < 64; i++) ref_mem[i] = '0;
        st             = S_IDLE;
        clr_map        = 1'b1;
        rst_n          = 1'b0;
        host_req_valid = 1'b1;
        host_req_we    = 1'b1;
        host_req_addr  = 6'd9;
        host_req_wdata = 32'hA5A5A5A5;
        eng_done       = 1'b0;
        eng_wr_valid   = 1'b0;
        eng_wr_addr    = '0;
        eng_wr_data    = '0;
        eng_rd_addr    = '0;

        // Reset values, with a host write held to prove the map write is gated
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rsp_valid", 32'(host_rsp_valid), 32'd0);
        chk("rst_rsp_rdata", host_rsp_rdata, 32'd0);
        chk("rst_rsp_err", 32'(host_rsp_err), 32'd0);
        chk("rst_eng_start", 32'(eng_start), 32'd0);
        chk("rst_eng_abort", 32'(eng_abort), 32'd0);
        chk("rst_map_we", 32'(rm_reg_write), 32'd0);
        host_req_valid = 1'b0;
        clr_map        = 1'b0;
        rst_n          = 1'b1;

        // Plain write then read
        host_txn(1'b1, 6'd5, 32'hDEADBEEF, 1'b0);
        host_txn(1'b0, 6'd5, 32'h0, 1'b0);

        // Read the very next cycle after a write to the same address
        @(posedge clk); #1;
        host_req_valid = 1'b1; host_req_we = 1'b1; host_req_addr = 6'd7; host_req_wdata = 32'h0BADF00D;
        @(posedge clk); #1;
        host_req_we = 1'b0;
        ref_mem[7] = 32'h0BADF00D;
        @(negedge clk);
        chk("raw_wr_ack", host_rsp_rdata, 32'd0);
        @(posedge clk); #1;
        host_req_valid = 1'b0;
        @(negedge clk);
        chk("raw_rsp_valid", 32'(host_rsp_valid), 32'd1);
        chk("raw_rdata", host_rsp_rdata, 32'h0BADF00D);

        // Out-of-range accesses
        host_txn(1'b1, 6'd50, 32'h12345678, 1'b0);
        host_txn(1'b0, 6'd63, 32'h0, 1'b0);

        // Run-control: start, done, clear; plus illegal bits and CTRL/STATUS corner cases
        host_txn(1'b1, 6'd0, 32'h6, 1'b0);
        host_txn(1'b0, 6'd1, 32'h0, 1'b0);
        host_txn(1'b1, 6'd0, 32'h1, 1'b0);
        host_txn(1'b0, 6'd1, 32'h0, 1'b0);
        host_txn(1'b0, 6'd0, 32'h0, 1'b0);
        eng_done_pulse();
        host_txn(1'b0, 6'd1, 32'h0, 1'b0);
        host_txn(1'b1, 6'd1, 32'hFFFFFFFF, 1'b0);
        host_txn(1'b1, 6'd0, 32'h2, 1'b0);
        host_txn(1'b0, 6'd1, 32'h0, 1'b0);

        // START and CLEAR together in DONE restart the engine
        host_txn(1'b1, 6'd0, 32'h1, 1'b0);
        eng_done_pulse();
        host_txn(1'b1, 6'd0, 32'h3, 1'b0);
        host_txn(1'b0, 6'd1, 32'h0, 1'b0);

        // Abort coinciding with engine completion
        eng_write(6'd12, 32'hCAFE0012);
        host_txn(1'b1, 6'd0, 32'h4, 1'b1);
        host_txn(1'b0, 6'd1, 32'h0, 1'b0);
        eng_write(6'd13, 32'hCAFE0013);
        host_txn(1'b0, 6'd12, 32'h0, 1'b0);

        // Contention straight after reset: host first, then alternating
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        st = S_IDLE;
        host_txn(1'b1, 6'd0, 32'h1, 1'b0);
        hd[0] = 32'h11110000; hd[1] = 32'h11110001; hd[2] = 32'h11110002;
        ed[0] = 32'h22220000; ed[1] = 32'h22220001; ed[2] = 32'h22220002;
        hi = 0;
        ei = 0;
        @(posedge clk); #1;
        host_req_valid = 1'b1; host_req_we = 1'b1; host_req_addr = 6'd10; host_req_wdata = hd[0];
        eng_wr_valid   = 1'b1; eng_wr_addr = 6'd11; eng_wr_data = ed[0];
        for (int k = 0; k < 4; k++) begin
            gh = ((k % 2) == 0);
            @(negedge clk);
            chk("arb_host_ready", 32'(host_req_ready), 32'(gh));
            chk("arb_eng_ready", 32'(eng_wr_ready), 32'(!gh));
            chk("arb_wr_addr", 32'(rm_write_reg), gh ? 32'd10 : 32'd11);
            chk("arb_wr_data", rm_write_data, gh ? hd[hi] : ed[ei]);
            chk("arb_rsp_valid", 32'(host_rsp_valid), 32'(!gh));
            @(posedge clk); #1;
            if (gh) hi++; else ei++;
            host_req_wdata = hd[hi];
            eng_wr_data    = ed[ei];
        end
        host_req_valid = 1'b0;
        eng_wr_valid   = 1'b0;
        ref_mem[10] = hd[1];
        ref_mem[11] = ed[1];
        host_txn(1'b0, 6'd10, 32'h0, 1'b0);
        host_txn(1'b0, 6'd11, 32'h0, 1'b0);
        eng_read(6'd11);

        // Reset mid-RUN with a read in flight and a write presented during reset
        host_txn(1'b0, 6'd1, 32'h0, 1'b0);
        @(posedge clk); #1;
        host_req_valid = 1'b1; host_req_we = 1'b0; host_req_addr = 6'd5;
        @(negedge clk);
        rst_n          = 1'b0;
        host_req_we    = 1'b1;
        host_req_addr  = 6'd6;
        host_req_wdata = 32'h12345678;
        #1;
        chk("midrst_map_we", 32'(rm_reg_write), 32'd0);
        repeat (3) begin
            @(negedge clk);
            chk("midrst_rsp_valid", 32'(host_rsp_valid), 32'd0);
            chk("midrst_map_we", 32'(rm_reg_write), 32'd0);
            chk("midrst_abort", 32'(eng_abort), 32'd0);
        end
        host_req_valid = 1'b0;
        rst_n          = 1'b1;
        st             = S_IDLE;
        @(negedge clk);
        chk("postrst_rsp_valid", 32'(host_rsp_valid), 32'd0);
        host_txn(1'b0, 6'd1, 32'h0, 1'b0);
        host_txn(1'b0, 6'd6, 32'h0, 1'b0);

        // Randomised mix of host traffic, CTRL writes, engine events
        for (int it = 0; it < 80; it++) begin
            sel = $urandom_range(0, 9);
            ra  = 6'($urandom_range(0, 63));
            if (ra == 6'd2) ra = 6'd3;
            rd  = $urandom;
            if (sel <= 4) begin
                host_txn(1'($urandom_range(0, 1)), ra, rd, 1'($urandom_range(0, 3) == 0));
            end else if (sel == 5) begin
                host_txn(1'b1, 6'd0, 32'($urandom_range(0, 7)), 1'($urandom_range(0, 3) == 0));
            end else if (sel == 6) begin
                eng_done_pulse();
            end else if (sel == 7) begin
                eng_write(6'($urandom_range(3, 47)), rd);
            end else if (sel == 8) begin
                eng_read(ra);
            end else begin
                host_txn(1'b0, 6'd1, 32'h0, 1'b0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
